// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
//   lsu_state_e : FSM state encoding (idle, memory request, register write-back)
//   LB..SW      : RV32I funct3 width/sign encodings for loads and stores
package lsu_pkg;

  typedef enum logic [1:0] {StIdle, StReq, StWb} lsu_state_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

endpackage

// File: rtl/lsu_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
//   mem_req/mem_we/mem_addr/mem_wstrb/mem_wdata : request, driven by the master
//   mem_ack/mem_rdata                           : completion and read word, driven by memory
interface lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane steering for stores and extraction/extension for loads.
//   funct3_i, offset_i : access width/sign and byte offset within the word
//   store_data_i       : raw rs2 value; wstrb_o/wdata_o are the steered store lanes
//   rdata_i            : memory read word; load_value_o is the extended result
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_value_o
);

  logic [31:0] shifted;

  always_comb begin
    wstrb_o = 4'b1111;
    wdata_o = store_data_i;
    case (funct3_i)
      SB: begin
        wstrb_o = 4'b0001 << offset_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      SH: begin
        wstrb_o = 4'b0011 << offset_i;
        wdata_o = {2{store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted      = rdata_i >> {offset_i, 3'b000};
    load_value_o = shifted;
    case (funct3_i)
      LB:      load_value_o = {{24{shifted[7]}}, shifted[7:0]};
      LH:      load_value_o = {{16{shifted[15]}}, shifted[15:0]};
      LBU:     load_value_o = {24'h0, shifted[7:0]};
      LHU:     load_value_o = {16'h0, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one memory operation at a time from execute,
// rejects illegal/misaligned accesses with a one-cycle fault pulse, issues the
// data-memory request and writes load results back to the register file.
//   clock, reset_n              : clock and synchronous active-low reset
//   op_valid/op_ready           : operation handshake (ready only when idle)
//   op_load, op_store, funct3   : operation kind and width/sign
//   address, store_data, rd     : effective address, rs2 value, destination
//   mem                         : data-memory bus (master side)
//   write_enable, rd_out, rd_value : register-file write port
//   misaligned, illegal         : fault pulses
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic        op_load,
  input  logic        op_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  lsu_if.master       mem,
  output logic        write_enable,
  output logic [4:0]  rd_out,
  output logic [31:0] rd_value,
  output logic        misaligned,
  output logic        illegal
);

  lsu_state_e  state_q, state_d;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] store_data_q;
  logic [4:0]  rd_q;
  logic        we_q;
  logic [4:0]  rd_out_q;
  logic [31:0] rd_value_q;
  logic        misaligned_q, illegal_q;

  logic        accept, is_mem_op, illegal_c, misaligned_c, start;
  logic [3:0]  wstrb;
  logic [31:0] wdata, load_value;

  assign op_ready  = (state_q == StIdle);
  assign accept    = op_valid & op_ready;
  assign is_mem_op = op_load | op_store;

  always_comb begin
    illegal_c = (op_load & op_store) |
                (op_load & ((funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111))) |
                (op_store & (funct3 >= 3'b011));
    // Illegal wins, so misaligned is only flagged for otherwise-legal accesses.
    misaligned_c = ~illegal_c & is_mem_op &
                   (((funct3[1:0] == 2'b01) & address[0]) |
                    ((funct3[1:0] == 2'b10) & (address[1:0] != 2'b00)));
    start = accept & is_mem_op & ~illegal_c & ~misaligned_c;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StReq;
      StReq:   if (mem.mem_ack) state_d = we_q ? StIdle : StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      funct3_q     <= 3'b000;
      addr_q       <= 32'h0;
      store_data_q <= 32'h0;
      rd_q         <= 5'd0;
      we_q         <= 1'b0;
      rd_out_q     <= 5'd0;
      rd_value_q   <= 32'h0;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      misaligned_q <= accept & misaligned_c;
      illegal_q    <= accept & illegal_c;
      if (accept) begin
        funct3_q     <= funct3;
        addr_q       <= address;
        store_data_q <= store_data;
        rd_q         <= rd;
        we_q         <= op_store & ~op_load;
      end
      if ((state_q == StReq) && mem.mem_ack && !we_q) begin
        rd_out_q   <= rd_q;
        rd_value_q <= load_value;
      end
    end
  end

  lsu_align u_align (
    .funct3_i     (funct3_q),
    .offset_i     (addr_q[1:0]),
    .store_data_i (store_data_q),
    .rdata_i      (mem.mem_rdata),
    .wstrb_o      (wstrb),
    .wdata_o      (wdata),
    .load_value_o (load_value)
  );

  // Bus fields come straight from registers latched at accept, so they are
  // stable for the whole request.
  assign mem.mem_req   = (state_q == StReq);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = {addr_q[31:2], 2'b00};
  assign mem.mem_wstrb = we_q ? wstrb : 4'b0000;
  assign mem.mem_wdata = wdata;

  assign write_enable = (state_q == StWb) && (rd_q != 5'd0);
  assign rd_out       = rd_out_q;
  assign rd_value     = rd_value_q;
  assign misaligned   = misaligned_q;
  assign illegal      = illegal_q;

endmodule
